mem_access_ctrl: RTL and testbench



---
 rtl/mem_pkg.sv | 22 ++
 rtl/mem_access_ctrl_lane_align.sv | 52 +++++
 rtl/mem_access_ctrl.sv | 135 +++++++++++++
 tb/tb_mem_access_ctrl.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared encodings and helpers for the memory-access controller.
package mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE  = 2'b00,
        SZ_HALF  = 2'b01,
        SZ_WORD  = 2'b10,
        SZ_DWORD = 2'b11
    } size_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_WAIT,
        ST_DONE
    } state_t;

    function automatic int unsigned size_bytes(input logic [1:0] sz);
        return 32'd1 << sz;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_lane_align.sv
// Big-endian lane steering: byte enables, store replication, load extraction/extension.
module lane_align
    import mem_pkg::*;
#(
    parameter int DATA_W = 32,
    localparam int LANES = DATA_W / 8,
    localparam int OFS_W = $clog2(LANES)
) (
    input  logic [1:0]        size,
    input  logic [OFS_W-1:0]  offset,
    input  logic              sign_ext,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata_raw,
    output logic [LANES-1:0]  be,
    output logic [DATA_W-1:0] wdata_rep,
    output logic [DATA_W-1:0] rdata_ext,
    output logic              align_err
);

    int unsigned       nb;
    int unsigned       ofs;
    logic [DATA_W-1:0] lane_src;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] msb_src;
    logic              fill;

    always_comb begin
        nb        = size_bytes(size);
        ofs       = 32'(offset);
        align_err = (nb > LANES) || ((ofs & (nb - 1)) != 0);
        if (nb > LANES)
            nb = LANES;

        be        = '0;
        wdata_rep = '0;
        lane_src  = '0;
        // Lane i (offset i) sits at bit slice LANES-1-i; store bytes repeat MSB-first per group.
        for (int unsigned i = 0; i < LANES; i++) begin
            be[LANES-1-i] = (i >= ofs) && (i < ofs + nb);
            lane_src = wdata >> ((nb - 1 - (i % nb)) * 8);
            wdata_rep[(LANES-1-i)*8 +: 8] = lane_src[7:0];
        end

        shifted   = rdata_raw >> ((LANES - ofs - nb) * 8);
        msb_src   = shifted >> (nb * 8 - 1);
        fill      = sign_ext & msb_src[0];
        rdata_ext = '0;
        for (int unsigned j = 0; j < DATA_W; j++)
            rdata_ext[j] = (j < nb * 8) ? shifted[j] : fill;
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-access controller: request latch, legality check, RAM cycle with wait states, MOC handshake.
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int WAIT_CYC = 0,
    localparam int LANES   = DATA_W / 8,
    localparam int OFS_W   = $clog2(LANES)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    mov,
    input  logic                    rw,
    input  logic [1:0]              size,
    input  logic                    sign_ext,
    input  logic [ADDR_W-1:0]       addr,
    input  logic [DATA_W-1:0]       wdata,
    output logic                    moc,
    output logic [DATA_W-1:0]       rdata,
    output logic                    err,
    output logic                    busy,
    output logic                    ram_en,
    output logic                    ram_we,
    output logic [LANES-1:0]        ram_be,
    output logic [ADDR_W-OFS_W-1:0] ram_addr,
    output logic [DATA_W-1:0]       ram_wdata,
    input  logic [DATA_W-1:0]       ram_rdata
);

    state_t            state;
    logic [1:0]        size_q;
    logic [OFS_W-1:0]  ofs_q;
    logic              rw_q;
    logic              sext_q;
    logic [3:0]        wait_cnt;

    logic [1:0]        la_size;
    logic [OFS_W-1:0]  la_ofs;
    logic [LANES-1:0]  la_be;
    logic [DATA_W-1:0] la_wrep;
    logic [DATA_W-1:0] la_rdata;
    logic              la_err;

    // One aligner serves both the live request (IDLE) and the latched one (WAIT).
    assign la_size = (state == ST_IDLE) ? size : size_q;
    assign la_ofs  = (state == ST_IDLE) ? addr[OFS_W-1:0] : ofs_q;

    lane_align #(.DATA_W(DATA_W)) u_lane_align (
        .size      (la_size),
        .offset    (la_ofs),
        .sign_ext  (sext_q),
        .wdata     (wdata),
        .rdata_raw (ram_rdata),
        .be        (la_be),
        .wdata_rep (la_wrep),
        .rdata_ext (la_rdata),
        .align_err (la_err)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            size_q    <= '0;
            ofs_q     <= '0;
            rw_q      <= 1'b0;
            sext_q    <= 1'b0;
            wait_cnt  <= '0;
            moc       <= 1'b0;
            rdata     <= '0;
            err       <= 1'b0;
            busy      <= 1'b0;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_be    <= '0;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (mov) begin
                        size_q <= size;
                        ofs_q  <= addr[OFS_W-1:0];
                        rw_q   <= rw;
                        sext_q <= sign_ext;
                        busy   <= 1'b1;
                        if (la_err) begin
                            state <= ST_DONE;
                            moc   <= 1'b1;
                            err   <= 1'b1;
                        end else begin
                            // RAM strobes are registered here so they are live throughout ACCESS.
                            state     <= ST_ACCESS;
                            ram_en    <= 1'b1;
                            ram_we    <= ~rw;
                            ram_be    <= la_be;
                            ram_addr  <= addr[ADDR_W-1:OFS_W];
                            ram_wdata <= la_wrep;
                        end
                    end
                end
                ST_ACCESS: begin
                    ram_en    <= 1'b0;
                    ram_we    <= 1'b0;
                    ram_be    <= '0;
                    ram_addr  <= '0;
                    ram_wdata <= '0;
                    wait_cnt  <= 4'(WAIT_CYC);
                    state     <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (wait_cnt == '0) begin
                        if (rw_q)
                            rdata <= la_rdata;
                        moc   <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                ST_DONE: begin
                    if (!mov) begin
                        state <= ST_IDLE;
                        moc   <= 1'b0;
                        err   <= 1'b0;
                        rdata <= '0;
                        busy  <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: three instances (32b/0 wait, 32b/4 wait, 64b/3 wait) with RAM models.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        mov_a, mov_b, mov_c;
    logic        rw, sign_ext;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata32;
    logic [63:0] wdata64;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    // Instance A: DATA_W=32, WAIT_CYC=0
    logic        moc_a, err_a, busy_a, ram_en_a, ram_we_a;
    logic [31:0] rdata_a, ram_wdata_a, ram_rdata_a;
    logic [3:0]  ram_be_a;
    logic [29:0] ram_addr_a;

    mem_access_ctrl #(.DATA_W(32), .ADDR_W(32), .WAIT_CYC(0)) dut_a (
        .clk(clk), .reset(reset), .mov(mov_a), .rw(rw), .size(size), .sign_ext(sign_ext),
        .addr(addr), .wdata(wdata32), .moc(moc_a), .rdata(rdata_a), .err(err_a), .busy(busy_a),
        .ram_en(ram_en_a), .ram_we(ram_we_a), .ram_be(ram_be_a), .ram_addr(ram_addr_a),
        .ram_wdata(ram_wdata_a), .ram_rdata(ram_rdata_a)
    );

    // Instance B: DATA_W=32, WAIT_CYC=4
    logic        moc_b, err_b, busy_b, ram_en_b, ram_we_b;
    logic [31:0] rdata_b, ram_wdata_b, ram_rdata_b;
    logic [3:0]  ram_be_b;
    logic [29:0] ram_addr_b;

    mem_access_ctrl #(.DATA_W(32), .ADDR_W(32), .WAIT_CYC(4)) dut_b (
        .clk(clk), .reset(reset), .mov(mov_b), .rw(rw), .size(size), .sign_ext(sign_ext),
        .addr(addr), .wdata(wdata32), .moc(moc_b), .rdata(rdata_b), .err(err_b), .busy(busy_b),
        .ram_en(ram_en_b), .ram_we(ram_we_b), .ram_be(ram_be_b), .ram_addr(ram_addr_b),
        .ram_wdata(ram_wdata_b), .ram_rdata(ram_rdata_b)
    );

    // Instance C: DATA_W=64, WAIT_CYC=3
    logic        moc_c, err_c, busy_c, ram_en_c, ram_we_c;
    logic [63:0] rdata_c, ram_wdata_c, ram_rdata_c;
    logic [7:0]  ram_be_c;
    logic [28:0] ram_addr_c;

    mem_access_ctrl #(.DATA_W(64), .ADDR_W(32), .WAIT_CYC(3)) dut_c (
        .clk(clk), .reset(reset), .mov(mov_c), .rw(rw), .size(size), .sign_ext(sign_ext),
        .addr(addr), .wdata(wdata64), .moc(moc_c), .rdata(rdata_c), .err(err_c), .busy(busy_c),
        .ram_en(ram_en_c), .ram_we(ram_we_c), .ram_be(ram_be_c), .ram_addr(ram_addr_c),
        .ram_wdata(ram_wdata_c), .ram_rdata(ram_rdata_c)
    );

    // RAM models: read data is garbage until 1+WAIT_CYC edges after the strobe edge.
    logic [31:0] mem_a [0:255];
    logic [31:0] mem_b [0:255];
    logic [63:0] mem_c [0:15];
    logic [31:0] rlat_a, rlat_b;
    logic [63:0] rlat_c;
    int rcnt_a = 0, rcnt_b = 0, rcnt_c = 0;
    int en_cnt_a = 0, we_cnt_a = 0, en_cnt_c = 0;
    logic [7:0]  last_be_c;
    logic [28:0] last_addr_c;

    assign ram_rdata_a = (rcnt_a == 0) ? rlat_a : 32'hDEAD_BEEF;
    assign ram_rdata_b = (rcnt_b == 0) ? rlat_b : 32'hDEAD_BEEF;
    assign ram_rdata_c = (rcnt_c == 0) ? rlat_c : 64'hDEAD_BEEF_DEAD_BEEF;

    always @(posedge clk) begin
        if (ram_en_a) begin
            en_cnt_a <= en_cnt_a + 1;
            if (ram_we_a) begin
                we_cnt_a <= we_cnt_a + 1;
                for (int i = 0; i < 4; i++)
                    if (ram_be_a[i]) mem_a[ram_addr_a[7:0]][8*i +: 8] <= ram_wdata_a[8*i +: 8];
            end
            rlat_a <= mem_a[ram_addr_a[7:0]];
            rcnt_a <= 0;
        end else if (rcnt_a != 0) rcnt_a <= rcnt_a - 1;

        if (ram_en_b) begin
            if (ram_we_b)
                for (int i = 0; i < 4; i++)
                    if (ram_be_b[i]) mem_b[ram_addr_b[7:0]][8*i +: 8] <= ram_wdata_b[8*i +: 8];
            rlat_b <= mem_b[ram_addr_b[7:0]];
            rcnt_b <= 4;
        end else if (rcnt_b != 0) rcnt_b <= rcnt_b - 1;

        if (ram_en_c) begin
            en_cnt_c    <= en_cnt_c + 1;
            last_be_c   <= ram_be_c;
            last_addr_c <= ram_addr_c;
            if (ram_we_c)
                for (int i = 0; i < 8; i++)
                    if (ram_be_c[i]) mem_c[ram_addr_c[3:0]][8*i +: 8] <= ram_wdata_c[8*i +: 8];
            rlat_c <= mem_c[ram_addr_c[3:0]];
            rcnt_c <= 3;
        end else if (rcnt_c != 0) rcnt_c <= rcnt_c - 1;
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Counts edges from the current point until the selected moc is seen high; 0 means timeout.
    task automatic wait_moc(input int which, output int edges);
        edges = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if ((which == 0 && moc_a) || (which == 1 && moc_b) || (which == 2 && moc_c)) begin
                edges = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        repeat (5) tick();
        vectors++;
        if ({moc_a, err_a, busy_a, ram_en_a, ram_we_a} !== 5'b0) begin
            errors++; $display("FAIL reset_flags: got %b want 00000", {moc_a, err_a, busy_a, ram_en_a, ram_we_a});
        end
        vectors++;
        if (rdata_a !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", rdata_a); end
        vectors++;
        if ({ram_be_a, ram_addr_a, ram_wdata_a} !== '0) begin
            errors++; $display("FAIL reset_ram_bus: be %b addr %h wdata %h want all 0", ram_be_a, ram_addr_a, ram_wdata_a);
        end
        vectors++;
        if ({busy_b, busy_c, moc_b, moc_c, ram_en_c} !== 5'b0) begin
            errors++; $display("FAIL reset_other: got %b want 00000", {busy_b, busy_c, moc_b, moc_c, ram_en_c});
        end
    endtask

    task automatic test_read_byte();
        logic [31:0] exp [2];
        exp[0] = 32'hFFFF_FFFF;
        exp[1] = 32'h0000_00FF;
        for (int k = 0; k < 2; k++) begin
            addr = 32'h41; size = 2'b00; rw = 1'b1; sign_ext = (k == 0); mov_a = 1'b1;
            tick();
            vectors++;
            if ({ram_en_a, ram_we_a, ram_be_a, ram_addr_a, moc_a} !== {1'b1, 1'b0, 4'b0100, 30'h10, 1'b0}) begin
                errors++; $display("FAIL rdb_access: en %b we %b be %b addr %h moc %b want 1 0 0100 10 0",
                                   ram_en_a, ram_we_a, ram_be_a, ram_addr_a, moc_a);
            end
            tick();
            vectors++;
            if (moc_a !== 1'b0) begin errors++; $display("FAIL rdb_edge2: moc %b want 0", moc_a); end
            tick();
            vectors++;
            if ({moc_a, err_a, rdata_a} !== {1'b1, 1'b0, exp[k]}) begin
                errors++; $display("FAIL rdb_data[%0d]: moc %b err %b rdata %h want 1 0 %h", k, moc_a, err_a, rdata_a, exp[k]);
            end
            mov_a = 1'b0;
            tick();
            vectors++;
            if ({moc_a, busy_a, rdata_a} !== 34'h0) begin
                errors++; $display("FAIL rdb_exit: moc %b busy %b rdata %h want 0 0 0", moc_a, busy_a, rdata_a);
            end
            tick();
        end
    endtask

    task automatic test_write_half();
        int we_before;
        addr = 32'h102; size = 2'b01; rw = 1'b0; sign_ext = 1'b0; wdata32 = 32'h0000_BEEF; mov_a = 1'b1;
        tick();
        we_before = we_cnt_a;
        vectors++;
        if ({ram_en_a, ram_we_a, ram_be_a, ram_addr_a, ram_wdata_a} !== {1'b1, 1'b1, 4'b0011, 30'h40, 32'hBEEF_BEEF}) begin
            errors++; $display("FAIL wrh_access: en %b we %b be %b addr %h wdata %h want 1 1 0011 40 beefbeef",
                               ram_en_a, ram_we_a, ram_be_a, ram_addr_a, ram_wdata_a);
        end
        wdata32 = 32'h1111_1111;
        tick();
        vectors++;
        if ({ram_en_a, ram_we_a} !== 2'b00) begin errors++; $display("FAIL wrh_we_drop: en/we %b want 00", {ram_en_a, ram_we_a}); end
        tick();
        vectors++;
        if ({moc_a, err_a, rdata_a} !== {1'b1, 1'b0, 32'h0}) begin
            errors++; $display("FAIL wrh_done: moc %b err %b rdata %h want 1 0 0", moc_a, err_a, rdata_a);
        end
        repeat (3) tick();
        vectors++;
        if (moc_a !== 1'b1) begin errors++; $display("FAIL wrh_moc_hold: moc %b want 1", moc_a); end
        vectors++;
        if (we_cnt_a - we_before !== 1) begin errors++; $display("FAIL wrh_we_count: %0d want 1", we_cnt_a - we_before); end
        vectors++;
        if (mem_a[8'h40] !== 32'h0000_BEEF) begin errors++; $display("FAIL wrh_mem: %h want 0000beef", mem_a[8'h40]); end
        mov_a = 1'b0;
        tick();
        vectors++;
        if (moc_a !== 1'b0) begin errors++; $display("FAIL wrh_exit: moc %b want 0", moc_a); end
        tick();
    endtask

    task automatic test_illegal();
        int en_before;
        int edges;
        en_before = en_cnt_a;
        addr = 32'h6; size = 2'b10; rw = 1'b1; mov_a = 1'b1;
        wait_moc(0, edges);
        vectors++;
        if ({edges, err_a} !== {32'd1, 1'b1}) begin errors++; $display("FAIL misalign: edges %0d err %b want 1 1", edges, err_a); end
        mov_a = 1'b0;
        tick();
        vectors++;
        if ({moc_a, err_a} !== 2'b00) begin errors++; $display("FAIL misalign_exit: moc/err %b want 00", {moc_a, err_a}); end
        tick();
        addr = 32'h0; size = 2'b11; mov_a = 1'b1;
        wait_moc(0, edges);
        vectors++;
        if ({edges, err_a} !== {32'd1, 1'b1}) begin errors++; $display("FAIL dword_on32: edges %0d err %b want 1 1", edges, err_a); end
        mov_a = 1'b0;
        repeat (2) tick();
        vectors++;
        if (en_cnt_a !== en_before) begin errors++; $display("FAIL illegal_no_ram: strobes %0d want 0", en_cnt_a - en_before); end
    endtask

    task automatic test_wait_states();
        int edges;
        addr = 32'h20; size = 2'b10; rw = 1'b1; sign_ext = 1'b0; mov_b = 1'b1;
        wait_moc(1, edges);
        vectors++;
        if (edges !== 7) begin errors++; $display("FAIL wait4_latency: edges %0d want 7", edges); end
        vectors++;
        if (rdata_b !== 32'h1234_5678) begin errors++; $display("FAIL wait4_rdata: %h want 12345678", rdata_b); end
        mov_b = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_back_to_back();
        int edges;
        addr = 32'h20; size = 2'b10; rw = 1'b1; mov_b = 1'b1;
        repeat (3) tick();
        mov_b = 1'b0;
        addr = 32'h5;
        wait_moc(1, edges);
        vectors++;
        if ({edges, rdata_b} !== {32'd4, 32'h1234_5678}) begin
            errors++; $display("FAIL drop_latency: edges %0d rdata %h want 4 12345678", edges, rdata_b);
        end
        tick();
        vectors++;
        if ({moc_b, busy_b, ram_en_b} !== 3'b000) begin
            errors++; $display("FAIL drop_pulse: moc/busy/en %b want 000", {moc_b, busy_b, ram_en_b});
        end
        addr = 32'h20; mov_b = 1'b1;
        tick();
        vectors++;
        if ({busy_b, ram_en_b, moc_b} !== 3'b110) begin
            errors++; $display("FAIL next_accept: busy/en/moc %b want 110", {busy_b, ram_en_b, moc_b});
        end
        wait_moc(1, edges);
        mov_b = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_dword64();
        int edges;
        addr = 32'h8; size = 2'b11; rw = 1'b1; sign_ext = 1'b0; mov_c = 1'b1;
        wait_moc(2, edges);
        vectors++;
        if (edges !== 6) begin errors++; $display("FAIL d64_latency: edges %0d want 6", edges); end
        vectors++;
        if ({last_be_c, last_addr_c} !== {8'hFF, 29'h1}) begin
            errors++; $display("FAIL d64_be_addr: be %h addr %h want ff 1", last_be_c, last_addr_c);
        end
        vectors++;
        if ({err_c, rdata_c} !== {1'b0, 64'h0123_4567_89AB_CDEF}) begin
            errors++; $display("FAIL d64_rdata: err %b rdata %h want 0 0123456789abcdef", err_c, rdata_c);
        end
        mov_c = 1'b0;
        repeat (2) tick();
        addr = 32'hE; size = 2'b01; sign_ext = 1'b1; mov_c = 1'b1;
        wait_moc(2, edges);
        vectors++;
        if ({last_be_c, rdata_c} !== {8'h03, 64'hFFFF_FFFF_FFFF_CDEF}) begin
            errors++; $display("FAIL h64_sext: be %h rdata %h want 03 ffffffffffffcdef", last_be_c, rdata_c);
        end
        mov_c = 1'b0;
        repeat (2) tick();
        addr = 32'hC; size = 2'b11; sign_ext = 1'b0; mov_c = 1'b1;
        wait_moc(2, edges);
        vectors++;
        if ({edges, err_c} !== {32'd1, 1'b1}) begin errors++; $display("FAIL d64_misalign: edges %0d err %b want 1 1", edges, err_c); end
        mov_c = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_reset_mid();
        logic moc_seen;
        int   en_before;
        addr = 32'h8; size = 2'b11; rw = 1'b1; mov_c = 1'b1;
        repeat (3) tick();
        vectors++;
        if ({busy_c, ram_en_c, moc_c} !== 3'b100) begin
            errors++; $display("FAIL rstmid_in_wait: busy/en/moc %b want 100", {busy_c, ram_en_c, moc_c});
        end
        reset = 1'b1; mov_c = 1'b0;
        tick();
        vectors++;
        if ({busy_c, ram_en_c, moc_c, err_c} !== 4'b0000) begin
            errors++; $display("FAIL rstmid_abort: busy/en/moc/err %b want 0000", {busy_c, ram_en_c, moc_c, err_c});
        end
        reset = 1'b0;
        en_before = en_cnt_c;
        moc_seen = 1'b0;
        repeat (10) begin
            tick();
            if (moc_c) moc_seen = 1'b1;
        end
        vectors++;
        if ({moc_seen, busy_c, 32'(en_cnt_c - en_before)} !== 34'h0) begin
            errors++; $display("FAIL rstmid_quiet: moc_seen %b busy %b strobes %0d want 0 0 0", moc_seen, busy_c, en_cnt_c - en_before);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = 32'h0;
            mem_b[i] = 32'h0;
        end
        for (int i = 0; i < 16; i++) mem_c[i] = 64'h0;
        mem_a[8'h10] = 32'h80FF_1234;
        mem_b[8'h08] = 32'h1234_5678;
        mem_c[1]     = 64'h0123_4567_89AB_CDEF;

        reset = 1'b1; mov_a = 1'b0; mov_b = 1'b0; mov_c = 1'b0;
        rw = 1'b1; sign_ext = 1'b0; size = 2'b00; addr = '0; wdata32 = '0; wdata64 = '0;
        @(negedge clk);

        test_reset();
        test_read_byte();
        test_write_half();
        test_illegal();
        test_wait_states();
        test_back_to_back();
        test_dword64();
        test_reset_mid();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, vectors %0d", vectors);
        $fatal(1);
    end

endmodule
